led_frame_scheduler: RTL

Scan and frame-buffer controller for the 8x8 red/green LED matrix. It holds two frame banks (front and back) and sequences the row scan at a programmable rate with inter-row blanking. It swaps banks only at frame boundaries through a request/acknowledge handshake, so game logic can build the next frame without tearing. It sits between game logic and the matrix pins, and replaces the free-running scan counter.

---
 rtl/led_frame_scheduler_pkg.sv | 28 ++
 rtl/led_scan_timer.sv | 56 +++++
 rtl/led_frame_scheduler.sv | 101 ++++++++++
 3 files changed

// File: rtl/led_frame_scheduler_pkg.sv
//------------------------------------------------------------------------------
// Module      : led_pkg
// Description : Shared types and helpers for the 8x8 red/green LED matrix.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package led_pkg;

    localparam int ROWS = 8;
    localparam int COLS = 8;

    typedef logic [COLS-1:0] row_t;
    typedef row_t [ROWS-1:0] frame_t;

    typedef struct packed {
        frame_t red;
        frame_t green;
    } bank_t;

    // Active-low one-hot row select.
    function automatic row_t row_sel_n(input logic [2:0] idx);
        return ~(row_t'(1) << idx);
    endfunction

endpackage

`default_nettype wire

// File: rtl/led_scan_timer.sv
//------------------------------------------------------------------------------
// Module      : led_scan_timer
// Description : Row-scan prescaler and row counter with blanking window.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module led_scan_timer
    import led_pkg::*;
#(
    parameter int SCAN_DIV = 1000,
    parameter int BLANK    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    output logic [2:0] row_idx,
    output logic       row_tick,
    output logic       frame_boundary,
    output logic       blank
);

    localparam logic [15:0] c_div_last = 16'(SCAN_DIV - 1);

    logic [15:0] r_div_cnt;
    logic [2:0]  r_row_idx;

    assign row_idx        = r_row_idx;
    assign row_tick       = enable && (r_div_cnt == c_div_last);
    assign frame_boundary = row_tick && (r_row_idx == 3'(ROWS - 1));

    generate
        if (BLANK > 0) begin : g_blank_window
            assign blank = !enable || (r_div_cnt < 16'(BLANK));
        end else begin : g_no_blank
            assign blank = !enable;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_div_cnt <= '0;
            r_row_idx <= '0;
        end else if (enable) begin
            if (row_tick) begin
                r_div_cnt <= '0;
                r_row_idx <= r_row_idx + 3'd1;
            end else begin
                r_div_cnt <= r_div_cnt + 16'd1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/led_frame_scheduler.sv
//------------------------------------------------------------------------------
// Module      : led_frame_scheduler
// Description : Double-buffered LED matrix scan controller with tear-free swap.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module led_frame_scheduler
    import led_pkg::*;
#(
    parameter int SCAN_DIV = 1000,
    parameter int BLANK    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       wr_en,
    input  logic [2:0] wr_row,
    input  logic [7:0] wr_red,
    input  logic [7:0] wr_green,
    input  logic       swap_req,
    output logic       swap_ack,
    output logic       frame_start,
    output logic [2:0] row_idx,
    output logic [7:0] red_driver,
    output logic [7:0] green_driver,
    output logic [7:0] row_sink
);

    logic       w_row_tick;
    logic       w_frame_boundary;
    logic       w_blank;
    logic [2:0] w_row_idx;
    logic       w_swap;
    logic       w_back_sel;

    bank_t      r_bank [2];
    logic       r_front_sel;
    logic       r_pending;

    led_scan_timer #(
        .SCAN_DIV (SCAN_DIV),
        .BLANK    (BLANK)
    ) u_timer (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .row_idx        (w_row_idx),
        .row_tick       (w_row_tick),
        .frame_boundary (w_frame_boundary),
        .blank          (w_blank)
    );

    assign row_idx    = w_row_idx;
    assign w_back_sel = ~r_front_sel;
    // A request arriving on the boundary cycle itself still makes this frame.
    assign w_swap     = w_frame_boundary && (r_pending || swap_req);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bank[0]    <= '0;
            r_bank[1]    <= '0;
            r_front_sel  <= 1'b0;
            r_pending    <= 1'b0;
            swap_ack     <= 1'b0;
            frame_start  <= 1'b0;
            red_driver   <= '0;
            green_driver <= '0;
            row_sink     <= 8'hFF;
        end else begin
            // Back bank is chosen with the pre-swap select.
            if (wr_en) begin
                r_bank[w_back_sel].red[wr_row]   <= wr_red;
                r_bank[w_back_sel].green[wr_row] <= wr_green;
            end

            if (w_swap) begin
                r_front_sel <= ~r_front_sel;
                r_pending   <= 1'b0;
            end else if (swap_req) begin
                r_pending   <= 1'b1;
            end

            swap_ack    <= w_swap;
            frame_start <= w_row_tick && (w_row_idx == 3'(ROWS - 1));

            if (w_blank) begin
                red_driver   <= '0;
                green_driver <= '0;
                row_sink     <= 8'hFF;
            end else begin
                red_driver   <= r_bank[r_front_sel].red[w_row_idx];
                green_driver <= r_bank[r_front_sel].green[w_row_idx];
                row_sink     <= row_sel_n(w_row_idx);
            end
        end
    end

endmodule

`default_nettype wire
